// File: rtl/line_buf_pp.sv
// line_buf_pp -- ping-pong line buffer with two banks of DEPTH pixels each.
//
// A writer fills the write bank one pixel per accepted write. When the last
// pixel of a line is accepted, the banks swap so the reader sees a complete
// line, provided the reader has released its previous line. If it has not,
// the writer waits in W_WAIT until rd_release arrives.
//
// Handshakes:
//   - A write is accepted on a rising edge when wr_en && wr_ready.
//   - A read is served when rd_en && rd_avail && rd_addr < DEPTH. rd_pix and
//     rd_valid appear one cycle later. rd_pix holds its value otherwise.
//   - rd_release is only honoured while rd_avail is 1.
//
// Optional feature macro: LINE_BUF_PP_DROP_EN
//   Defined:   wr_ready stays 1 in W_WAIT. Writes made in W_WAIT are discarded
//              and counted in drop_cnt, which saturates at 255.
//   Undefined: W_WAIT drops wr_ready (back-pressure), and drop_cnt is 0.
//
// Ports:
//   clock, reset_n       single clock; synchronous active-low reset
//   wr_en, wr_data       write request; pixel is wr_data[PIX_W-1:0]
//   wr_ready             writer may present a pixel
//   wr_row               index of the last accepted pixel
//   line_done            one-cycle pulse after a line's last pixel
//   rd_en, rd_addr       read request and pixel index
//   rd_pix, rd_valid     registered read data and its strobe
//   rd_avail             a complete line is held in the read bank
//   rd_release           reader is done with the held line
//   drop_cnt             discarded-pixel count
//   dbg_state_o          write FSM state (0 = W_FILL, 1 = W_WAIT)
module line_buf_pp #(
   parameter int DEPTH  = 100,
   parameter int ADDR_W = 7,
   parameter int CH_W   = 8,
   parameter int NCH    = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [31:0]           wr_data,
   output logic                  wr_ready,
   output logic [ADDR_W-1:0]     wr_row,
   output logic                  line_done,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [NCH*CH_W-1:0]   rd_pix,
   output logic                  rd_valid,
   output logic                  rd_avail,
   input  logic                  rd_release,
   output logic [7:0]            drop_cnt,
   output logic                  dbg_state_o
);

   localparam int PIX_W = NCH * CH_W;

   typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wstate_e;

   wstate_e             state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0]   wr_row_q;
   logic                line_done_q;
   logic                rd_avail_q, rd_avail_d;
   logic [PIX_W-1:0]    rd_pix_q;
   logic                rd_valid_q;
   logic [7:0]          drop_cnt_q;

   logic [PIX_W-1:0]    mem_q [0:1][0:DEPTH-1];

   logic wr_acc;     // write accepted into the write bank
   logic wr_drop;    // write presented in W_WAIT (drop build only)
   logic last_pix;   // accepted write completes the line
   logic rel;        // qualified release
   logic swap;       // banks exchange on this edge
   logic rd_ok;      // qualifying read

   // The upper wr_data bits are unused for narrower pixels.
   if (PIX_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^wr_data[31:PIX_W];
   end

   assign rel      = rd_release && rd_avail_q;
   assign last_pix = wr_acc && (wr_ptr_q == ADDR_W'(DEPTH - 1));
   // A finished line swaps at once if the reader holds nothing, or if it is
   // releasing on the same edge. A waiting writer swaps on the release.
   assign swap     = (last_pix && (!rd_avail_q || rel)) ||
                     ((state_q == W_WAIT) && rel);
   assign rd_ok    = rd_en && rd_avail_q && (int'(rd_addr) < DEPTH);

   // ---------------- write FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= W_FILL;
      else          state_q <= state_d;
   end

   // ---------------- write FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         W_FILL: if (last_pix && rd_avail_q && !rel) state_d = W_WAIT;
         W_WAIT: if (rel)                            state_d = W_FILL;
         default:                                    state_d = W_FILL;
      endcase
   end

   // ---------------- write FSM: outputs ----------------
   always_comb begin
`ifdef LINE_BUF_PP_DROP_EN
      wr_ready = 1'b1;
      wr_acc   = wr_en && (state_q == W_FILL);
      wr_drop  = wr_en && (state_q == W_WAIT);
`else
      wr_ready = (state_q == W_FILL);
      wr_acc   = wr_en && (state_q == W_FILL);
      wr_drop  = 1'b0;
`endif
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      wr_bank_d  = wr_bank_q;
      rd_avail_d = rd_avail_q;
      if (wr_acc) begin
         wr_ptr_d = last_pix ? '0 : wr_ptr_q + 1'b1;
      end
      if (swap) begin
         wr_bank_d  = ~wr_bank_q;
         rd_avail_d = 1'b1;
      end else if (rel) begin
         rd_avail_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         wr_bank_q   <= 1'b0;
         wr_row_q    <= '0;
         line_done_q <= 1'b0;
         rd_avail_q  <= 1'b0;
         rd_pix_q    <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         wr_bank_q   <= wr_bank_d;
         line_done_q <= last_pix;
         rd_avail_q  <= rd_avail_d;
         rd_valid_q  <= rd_ok;
         if (wr_acc) wr_row_q <= wr_ptr_q;
         // The read bank is the one not being written, taken before any
         // swap on this edge.
         if (rd_ok)  rd_pix_q <= mem_q[~wr_bank_q][rd_addr];
      end
   end

   // Bank storage is not reset.
   always_ff @(posedge clock) begin
      if (wr_acc) mem_q[wr_bank_q][wr_ptr_q] <= wr_data[PIX_W-1:0];
   end

`ifdef LINE_BUF_PP_DROP_EN
   always_ff @(posedge clock) begin
      if (!reset_n)                          drop_cnt_q <= 8'd0;
      else if (wr_drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
   end
`else
   logic unused_drop;
   assign unused_drop = wr_drop;
   assign drop_cnt_q  = 8'd0;
`endif

   assign wr_row      = wr_row_q;
   assign line_done   = line_done_q;
   assign rd_avail    = rd_avail_q;
   assign rd_pix      = rd_pix_q;
   assign rd_valid    = rd_valid_q;
   assign drop_cnt    = drop_cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_line_buf_pp.sv
module tb_line_buf_pp;
   localparam int ADDR_W = 7;
   localparam int PIX_W  = 24;

   logic              clock      = 1'b0;
   logic              reset_n    = 1'b0;
   logic              wr_en      = 1'b0;
   logic [31:0]       wr_data    = '0;
   logic              rd_en      = 1'b0;
   logic [ADDR_W-1:0] rd_addr    = '0;
   logic              rd_release = 1'b0;
   logic              wr_ready, line_done, rd_valid, rd_avail, dbg_state;
   logic [ADDR_W-1:0] wr_row;
   logic [PIX_W-1:0]  rd_pix;
   logic [7:0]        drop_cnt;

   int n_cmp  = 0;
   int n_err  = 0;
   int ld_cnt = 0;
   logic [31:0] exp_q[$];

   line_buf_pp dut (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_row(wr_row), .line_done(line_done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_pix(rd_pix), .rd_valid(rd_valid),
      .rd_avail(rd_avail), .rd_release(rd_release), .drop_cnt(drop_cnt),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // line_done pulse counter, sampled mid-cycle
   always @(negedge clock) if (line_done) ld_cnt++;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_pix(input logic [31:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic write_run(input int base, input int n);
      for (int i = 0; i < n; i++) write_pix(32'(base + i));
   endtask

   task automatic release_line();
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
   endtask

   task automatic read_pix(input int a, input logic exp_valid, input logic [31:0] exp_pix);
      exp_q.push_back(exp_pix);
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(a);
      tick();
      rd_en   = 1'b0;
      check($sformatf("rd_valid@%0d", a), 32'(rd_valid), 32'(exp_valid));
      check($sformatf("rd_pix@%0d", a), 32'(rd_pix), exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      check("rst_wr_ready", 32'(wr_ready), 1);
      check("rst_wr_row", 32'(wr_row), 0);
      check("rst_line_done", 32'(line_done), 0);
      check("rst_rd_avail", 32'(rd_avail), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_pix", 32'(rd_pix), 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);

      // first line 0..99 with nothing held
      write_run(0, 99);
      check("l1_no_early_done", 32'(ld_cnt), 0);
      write_pix(99);
      check("l1_line_done", 32'(line_done), 1);
      check("l1_rd_avail", 32'(rd_avail), 1);
      check("l1_wr_row", 32'(wr_row), 99);
      check("l1_wr_ready", 32'(wr_ready), 1);
      tick();
      check("l1_done_pulse", 32'(line_done), 0);
      check("l1_done_count", 32'(ld_cnt), 1);

      read_pix(42, 1'b1, 42);
      tick();
      check("hold_rd_valid", 32'(rd_valid), 0);
      check("hold_rd_pix", 32'(rd_pix), 42);
      read_pix(0, 1'b1, 0);
      read_pix(99, 1'b1, 99);
      read_pix(100, 1'b0, 99);    // out of range: pix held
      read_pix(127, 1'b0, 99);

      // second line while the first is still held
      write_run(100, 100);
      check("l2_rd_avail", 32'(rd_avail), 1);
      check("l2_wait_state", 32'(dbg_state), 1);
      check("l2_wr_row", 32'(wr_row), 99);
`ifdef LINE_BUF_PP_DROP_EN
      for (int i = 0; i < 300; i++) begin
         write_pix(32'(1000 + i));
         check("drop_wr_ready", 32'(wr_ready), 1);
      end
      check("drop_cnt_sat", 32'(drop_cnt), 255);
      check("drop_wr_row", 32'(wr_row), 99);
`else
      check("l2_wr_ready", 32'(wr_ready), 0);
      write_pix(777);             // blocked, must not land
      check("bp_wr_row", 32'(wr_row), 99);
      check("bp_drop_cnt", 32'(drop_cnt), 0);
`endif
      read_pix(5, 1'b1, 5);       // still the first line
      release_line();
      check("rel_wr_ready", 32'(wr_ready), 1);
      check("rel_rd_avail", 32'(rd_avail), 1);
      check("rel_state", 32'(dbg_state), 0);
      read_pix(0, 1'b1, 100);
      read_pix(99, 1'b1, 199);

      // third line with release on the last pixel's edge
      write_run(200, 99);
      wr_en      = 1'b1;
      wr_data    = 299;
      rd_release = 1'b1;
      tick();
      wr_en      = 1'b0;
      rd_release = 1'b0;
      check("l3_wr_ready", 32'(wr_ready), 1);
      check("l3_rd_avail", 32'(rd_avail), 1);
      check("l3_state", 32'(dbg_state), 0);
      check("l3_line_done", 32'(line_done), 1);
      read_pix(0, 1'b1, 200);
      read_pix(99, 1'b1, 299);

      // release with no new line: reads now refused
      release_line();
      check("empty_rd_avail", 32'(rd_avail), 0);
      read_pix(3, 1'b0, 299);
      release_line();             // ignored
      check("ign_rel_rd_avail", 32'(rd_avail), 0);

      // reset mid-line
      write_run(500, 50);
      check("part_wr_row", 32'(wr_row), 49);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mid_rst_wr_row", 32'(wr_row), 0);
      check("mid_rst_rd_avail", 32'(rd_avail), 0);
      check("mid_rst_rd_pix", 32'(rd_pix), 0);
      write_run(600, 99);
      check("l4_not_yet", 32'(rd_avail), 0);
      write_pix(699);
      check("l4_rd_avail", 32'(rd_avail), 1);
      check("l4_wr_row", 32'(wr_row), 99);
      read_pix(0, 1'b1, 600);
      read_pix(49, 1'b1, 649);
      read_pix(99, 1'b1, 699);
      tick();
      check("total_line_done", 32'(ld_cnt), 4);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
